dsram_arbiter: RTL and testbench
================================

Name: dsram_arbiter

Overview:
- Shares the single-port, 1-cycle-latency data SRAM between the pipeline load/store path (EX issues, MEM consumes) and one auxiliary requester (DMA/debug).
- Pipeline has default priority; starvation counter forces an aux grant and raises a stall request to CTRL.
- Keeps the read data seen by MEM stable across aux accesses and pipeline stalls.

Parameters:
- STARVE_LIMIT, 4, aux-waiting cycles before aux is forced ahead of the pipeline (1..15)
- CNT_W, 4, width of the starvation counter

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- stall  in  `StallBus  stall vector from CTRL; bit 3 = MEM stage
- cpu_en  in  1  pipeline SRAM request (from EX)
- cpu_we  in  4  pipeline byte write enables; 0 = read
- cpu_addr  in  32  pipeline word address
- cpu_wdata  in  32  pipeline store data
- cpu_rdata  out  32  load data to MEM stage
- stallreq  out  1  stall request to CTRL
- aux_req  in  1  aux request, held until aux_gnt
- aux_we  in  4  aux byte write enables
- aux_addr  in  32  aux address
- aux_wdata  in  32  aux store data
- aux_gnt  out  1  aux request accepted this cycle
- aux_rvalid  out  1  aux read data valid
- aux_rdata  out  32  aux read data
- sram_en  out  1  SRAM enable
- sram_we  out  4  SRAM byte write enables
- sram_addr  out  32  SRAM address
- sram_wdata  out  32  SRAM write data
- sram_rdata  in  32  SRAM read data, valid the cycle after enable

Behaviour:
- Reset: wait_cnt=0, rsel=NONE, rdata_hold=0, aux_rvalid=0; with all requests low, every output is 0.
- Grant logic (combinational):
  - force = aux_req && wait_cnt>=STARVE_LIMIT.
  - gnt_aux = aux_req && (!cpu_en || force).
  - gnt_cpu = cpu_en && !gnt_aux.
- SRAM mux:
  - sram_* driven from the granted requester; sram_en = gnt_cpu | gnt_aux.
  - No grant: sram_en=0, sram_we=0.
- Stall request: stallreq = cpu_en && gnt_aux.
  - EX holds and reissues the same request next cycle.
  - Reissued stores are idempotent.
- aux_gnt = gnt_aux.
- wait_cnt:
  - cleared on gnt_aux or !aux_req.
  - otherwise +1 when aux_req && !gnt_aux, saturating at 2^CNT_W-1.
- Read-owner register rsel, next cycle:
  - CPU if gnt_cpu && cpu_we==0.
  - AUX if gnt_aux && aux_we==0.
  - else NONE.
- CPU data path:
  - rsel==CPU: cpu_rdata = sram_rdata, and rdata_hold <= sram_rdata.
  - otherwise: cpu_rdata = rdata_hold.
  - Result: data stays stable while MEM is stalled (stall[3]=Stop) and during aux cycles.
- Aux read:
  - aux_rvalid is registered and high exactly 1 cycle after an aux read grant.
  - aux_rdata = sram_rdata (valid only with aux_rvalid).
- Latency:
  - Pipeline read: data 1 cycle after grant.
  - Aux: grant same cycle as request if pipeline idle; otherwise at most STARVE_LIMIT+1 cycles later.
- Simultaneous events:
  - cpu_en && aux_req below limit → cpu wins, counter increments.
  - At limit → aux wins, stallreq=1.
- Write grants never change rdata_hold.
- Reset mid-operation: pending aux_rvalid and rsel are dropped; no response is produced for an in-flight read.

Decomposition:
- Shared defines header (existing lib/defines.vh): `StallBus`, `Stop`/`NoStop`, plus new RSEL_NONE/RSEL_CPU/RSEL_AUX encodings (2 bits).
- No sub-module needed; grant, counter and data-hold logic stay in one module.

Test Plan:
- Pipeline-only read: cpu_en=1, cpu_we=0, addr=0x100, SRAM returns 0xDEADBEEF → sram_en=1 same cycle; cpu_rdata=0xDEADBEEF next cycle; stallreq stays 0.
- Aux with idle pipeline: aux_req=1, aux_we=0, addr=0x200 → aux_gnt=1 same cycle; aux_rvalid=1 next cycle with sram_rdata; wait_cnt stays 0.
- Starvation, STARVE_LIMIT=4: cpu_en and aux_req held high → cpu granted cycles 0-3; cycle 4 aux_gnt=1 and stallreq=1; cycle 5 cpu regranted, wait_cnt=0.
- Data hold: cpu read returns 0x12345678, then aux read returns 0xAAAA5555 with stall[3]=Stop → cpu_rdata remains 0x12345678 throughout.
- Aux write: aux_we=4'b0011, wdata=0x0000BEEF → sram_we=4'b0011; no aux_rvalid; rdata_hold unchanged.
- Reset mid-read: aux read granted, rst=1 next cycle → aux_rvalid=0, rsel=NONE, cpu_rdata=0.

Source files
------------

// File: rtl/dsram_arbiter_pkg.sv
// Shared types for the data-SRAM arbiter: CTRL stall bus layout and the
// read-owner encoding that steers SRAM read data back to its requester.
package dsram_arbiter_pkg;

  localparam int STALL_W   = 6;
  localparam int STALL_MEM = 3;
  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  typedef logic [STALL_W-1:0] stall_bus_t;

  typedef enum logic [1:0] {
    RSEL_NONE = 2'b00,
    RSEL_CPU  = 2'b01,
    RSEL_AUX  = 2'b10
  } rsel_e;

  function automatic logic is_read(input logic [3:0] we);
    return (we == 4'b0000);
  endfunction

endpackage

// File: rtl/dsram_arbiter_if.sv
// Bundle of pipeline, auxiliary and SRAM-side signals around the arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface dsram_arbiter_if;
  import dsram_arbiter_pkg::*;

  stall_bus_t  stall;
  logic        cpu_en;
  logic [3:0]  cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        stallreq;
  logic        aux_req;
  logic [3:0]  aux_we;
  logic [31:0] aux_addr;
  logic [31:0] aux_wdata;
  logic        aux_gnt;
  logic        aux_rvalid;
  logic [31:0] aux_rdata;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  modport slave (
    input  stall, cpu_en, cpu_we, cpu_addr, cpu_wdata,
    input  aux_req, aux_we, aux_addr, aux_wdata, sram_rdata,
    output cpu_rdata, stallreq, aux_gnt, aux_rvalid, aux_rdata,
    output sram_en, sram_we, sram_addr, sram_wdata
  );

  modport master (
    output stall, cpu_en, cpu_we, cpu_addr, cpu_wdata,
    output aux_req, aux_we, aux_addr, aux_wdata, sram_rdata,
    input  cpu_rdata, stallreq, aux_gnt, aux_rvalid, aux_rdata,
    input  sram_en, sram_we, sram_addr, sram_wdata
  );

endinterface

// File: rtl/dsram_arbiter.sv
// Arbitrates the single-port data SRAM between the pipeline and one aux
// requester, with a starvation counter and a hold register for load data.
module dsram_arbiter
  import dsram_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic           clk,
  input  logic           rst,
  dsram_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  rsel_e            rsel_q, rsel_d;
  logic [31:0]      rdata_hold_q, rdata_hold_d;
  logic             aux_rvalid_q, aux_rvalid_d;

  logic force_aux;
  logic gnt_aux;
  logic gnt_cpu;

  always_comb begin
    force_aux = bus.aux_req && (wait_cnt_q >= LIMIT);
    gnt_aux   = bus.aux_req && (!bus.cpu_en || force_aux);
    gnt_cpu   = bus.cpu_en && !gnt_aux;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q   <= '0;
      rsel_q       <= RSEL_NONE;
      rdata_hold_q <= '0;
      aux_rvalid_q <= 1'b0;
    end else begin
      wait_cnt_q   <= wait_cnt_d;
      rsel_q       <= rsel_d;
      rdata_hold_q <= rdata_hold_d;
      aux_rvalid_q <= aux_rvalid_d;
    end
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (gnt_aux || !bus.aux_req) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != CNT_MAX) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end

    rsel_d = RSEL_NONE;
    if (gnt_cpu && is_read(bus.cpu_we)) begin
      rsel_d = RSEL_CPU;
    end else if (gnt_aux && is_read(bus.aux_we)) begin
      rsel_d = RSEL_AUX;
    end

    aux_rvalid_d = (rsel_d == RSEL_AUX);
    // Only a completed pipeline read refreshes the hold; aux and write cycles leave it.
    rdata_hold_d = (rsel_q == RSEL_CPU) ? bus.sram_rdata : rdata_hold_q;
  end

  always_comb begin
    bus.sram_en    = gnt_cpu | gnt_aux;
    bus.sram_we    = '0;
    bus.sram_addr  = '0;
    bus.sram_wdata = '0;
    if (gnt_aux) begin
      bus.sram_we    = bus.aux_we;
      bus.sram_addr  = bus.aux_addr;
      bus.sram_wdata = bus.aux_wdata;
    end else if (gnt_cpu) begin
      bus.sram_we    = bus.cpu_we;
      bus.sram_addr  = bus.cpu_addr;
      bus.sram_wdata = bus.cpu_wdata;
    end

    bus.stallreq   = bus.cpu_en && gnt_aux;
    bus.aux_gnt    = gnt_aux;
    bus.aux_rvalid = aux_rvalid_q;
    bus.aux_rdata  = aux_rvalid_q ? bus.sram_rdata : '0;
    bus.cpu_rdata  = (rsel_q == RSEL_CPU) ? bus.sram_rdata : rdata_hold_q;
  end

endmodule

// File: tb/tb_dsram_arbiter.sv
// Randomised scoreboard bench for dsram_arbiter: a reference model predicts
// grants and read data; a monitor checks responses as the DUT presents them.
module tb_dsram_arbiter;
  import dsram_arbiter_pkg::*;

  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dsram_arbiter_if bus();

  dsram_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Behavioural SRAM: one access per cycle, read data one cycle after enable.
  logic [31:0] sram_mem [256];
  always @(posedge clk) begin
    if (bus.sram_en) begin
      if (bus.sram_we == 4'b0000) begin
        bus.sram_rdata <= sram_mem[bus.sram_addr[7:0]];
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (bus.sram_we[b]) sram_mem[bus.sram_addr[7:0]][8*b +: 8] <= bus.sram_wdata[8*b +: 8];
        end
      end
    end
  end

  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_t;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  rsp_t        aux_q[$];
  rsp_t        cpu_q[$];
  logic [31:0] exp_cpu = '0;
  logic [31:0] ref_mem [256];
  int          waited = 0;
  logic        last_gnt;
  logic        last_stallreq;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'b0, act}, {31'b0, exp});
  endtask

  // Model of one SRAM access: reads queue their data for the next cycle.
  task automatic access(input logic is_aux, input logic [3:0] we,
                        input logic [31:0] addr, input logic [31:0] wd);
    rsp_t r;
    if (we == 4'b0000) begin
      r.due  = cyc + 1;
      r.data = ref_mem[addr[7:0]];
      if (is_aux) aux_q.push_back(r);
      else        cpu_q.push_back(r);
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (we[b]) ref_mem[addr[7:0]][8*b +: 8] = wd[8*b +: 8];
      end
    end
  endtask

  task automatic drive_idle();
    bus.cpu_en = 1'b0; bus.cpu_we = '0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.aux_req = 1'b0; bus.aux_we = '0; bus.aux_addr = '0; bus.aux_wdata = '0;
    bus.stall = '0;
  endtask

  task automatic do_cycle(input logic c_en, input logic [3:0] c_we,
                          input logic [31:0] c_addr, input logic [31:0] c_wd,
                          input logic a_req, input logic [3:0] a_we,
                          input logic [31:0] a_addr, input logic [31:0] a_wd,
                          input stall_bus_t st);
    logic aux_wins, cpu_wins;
    @(posedge clk);
    #1;
    bus.cpu_en = c_en; bus.cpu_we = c_we; bus.cpu_addr = c_addr; bus.cpu_wdata = c_wd;
    bus.aux_req = a_req; bus.aux_we = a_we; bus.aux_addr = a_addr; bus.aux_wdata = a_wd;
    bus.stall = st;
    @(negedge clk);
    aux_wins = a_req && (!c_en || waited >= LIMIT);
    cpu_wins = c_en && !aux_wins;
    chk1("aux_gnt", bus.aux_gnt, aux_wins);
    chk1("stallreq", bus.stallreq, c_en && aux_wins);
    chk1("sram_en", bus.sram_en, aux_wins || cpu_wins);
    if (aux_wins) begin
      chk("sram_we_aux", {28'b0, bus.sram_we}, {28'b0, a_we});
      chk("sram_addr_aux", bus.sram_addr, a_addr);
      chk("sram_wdata_aux", bus.sram_wdata, a_wd);
      access(1'b1, a_we, a_addr, a_wd);
    end else if (cpu_wins) begin
      chk("sram_we_cpu", {28'b0, bus.sram_we}, {28'b0, c_we});
      chk("sram_addr_cpu", bus.sram_addr, c_addr);
      chk("sram_wdata_cpu", bus.sram_wdata, c_wd);
      access(1'b0, c_we, c_addr, c_wd);
    end else begin
      chk("sram_we_idle", {28'b0, bus.sram_we}, 32'h0);
    end
    if (aux_wins || !a_req) waited = 0;
    else                    waited++;
    last_gnt      = aux_wins;
    last_stallreq = c_en && aux_wins;
  endtask

  // Response monitor: registered outputs are checked mid-cycle against the queues.
  initial begin
    forever begin
      @(posedge clk);
      #3;
      if (!rst) begin
        if (aux_q.size() > 0 && aux_q[0].due == cyc) begin
          rsp_t r;
          r = aux_q.pop_front();
          chk1("aux_rvalid", bus.aux_rvalid, 1'b1);
          chk("aux_rdata", bus.aux_rdata, r.data);
          $display("aux read response data=%08h cycle=%0d", bus.aux_rdata, cyc);
        end else begin
          chk1("aux_rvalid_spurious", bus.aux_rvalid, 1'b0);
        end
        if (cpu_q.size() > 0 && cpu_q[0].due == cyc) begin
          exp_cpu = cpu_q.pop_front().data;
          $display("cpu read response data=%08h cycle=%0d", bus.cpu_rdata, cyc);
        end
        chk("cpu_rdata", bus.cpu_rdata, exp_cpu);
      end
    end
  end

  initial begin
    stall_bus_t  st_mem;
    logic [5:0]  gv;
    logic [5:0]  sv;
    logic        cpu_hold;
    logic        aux_pend;
    logic        c_en;
    logic [3:0]  c_we, a_we;
    logic [31:0] c_addr, c_wd, a_addr, a_wd;
    stall_bus_t  st;

    for (int i = 0; i < 256; i++) begin
      sram_mem[i] = $urandom;
      ref_mem[i]  = sram_mem[i];
    end
    bus.sram_rdata = '0;
    drive_idle();
    st_mem = '0;
    st_mem[STALL_MEM] = STOP;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_cpu_rdata", bus.cpu_rdata, 32'h0);
    chk("rst_aux_rdata", bus.aux_rdata, 32'h0);
    chk("rst_sram_addr", bus.sram_addr, 32'h0);
    chk("rst_sram_wdata", bus.sram_wdata, 32'h0);
    chk("rst_sram_we", {28'b0, bus.sram_we}, 32'h0);
    chk1("rst_stallreq", bus.stallreq, 1'b0);
    chk1("rst_aux_gnt", bus.aux_gnt, 1'b0);
    chk1("rst_aux_rvalid", bus.aux_rvalid, 1'b0);
    chk1("rst_sram_en", bus.sram_en, 1'b0);

    // Pipeline-only read of a known word.
    do_cycle(1'b1, 4'hF, 32'h100, 32'hDEADBEEF, 1'b0, 4'h0, 32'h0, 32'h0, '0);
    do_cycle(1'b1, 4'h0, 32'h100, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, '0);
    do_cycle(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, '0);
    chk("pipe_read_data", bus.cpu_rdata, 32'hDEADBEEF);

    // Aux read with idle pipeline: granted immediately.
    do_cycle(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h200, 32'h0, '0);
    chk1("aux_idle_gnt", bus.aux_gnt, 1'b1);
    do_cycle(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, '0);

    // Starvation: aux forced ahead on the fifth contended cycle.
    for (int i = 0; i < 6; i++) begin
      do_cycle(1'b1, 4'h0, 32'h4, 32'h0, (i < 5), 4'h0, 32'h8, 32'h0, '0);
      gv[i] = bus.aux_gnt;
      sv[i] = bus.stallreq;
    end
    chk("starve_gnt_pattern", {26'b0, gv}, 32'h10);
    chk("starve_stall_pattern", {26'b0, sv}, 32'h10);

    // Data hold across an aux read while MEM is stalled.
    do_cycle(1'b1, 4'hF, 32'h10, 32'h12345678, 1'b0, 4'h0, 32'h0, 32'h0, '0);
    do_cycle(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'hF, 32'h20, 32'hAAAA5555, '0);
    do_cycle(1'b1, 4'h0, 32'h10, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, '0);
    do_cycle(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h20, 32'h0, st_mem);
    chk("hold_during_aux", bus.cpu_rdata, 32'h12345678);
    do_cycle(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, st_mem);
    chk("hold_after_aux", bus.cpu_rdata, 32'h12345678);

    // Aux partial write leaves load data untouched.
    do_cycle(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'b0011, 32'h30, 32'h0000BEEF, '0);
    chk("aux_write_we", {28'b0, bus.sram_we}, 32'h3);
    do_cycle(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, '0);
    chk("hold_after_aux_write", bus.cpu_rdata, 32'h12345678);

    // Reset while an aux read is in flight: its response is dropped.
    do_cycle(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h3, 32'h0, '0);
    rst = 1'b1;
    drive_idle();
    aux_q.delete();
    cpu_q.delete();
    exp_cpu = '0;
    waited  = 0;
    @(negedge clk);
    chk1("midrst_aux_rvalid", bus.aux_rvalid, 1'b0);
    chk("midrst_cpu_rdata", bus.cpu_rdata, 32'h0);
    chk("midrst_aux_rdata", bus.aux_rdata, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Randomised traffic; EX reissues stalled requests, aux holds until granted.
    cpu_hold = 1'b0;
    aux_pend = 1'b0;
    c_en = 1'b0; c_we = '0; c_addr = '0; c_wd = '0;
    a_we = '0; a_addr = '0; a_wd = '0;
    for (int n = 0; n < 2000; n++) begin
      if (!cpu_hold) begin
        c_en   = ($urandom_range(0, 99) < 60);
        c_we   = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
        c_addr = 32'($urandom_range(0, 15));
        c_wd   = $urandom;
      end
      if (!aux_pend) begin
        aux_pend = ($urandom_range(0, 99) < 35);
        a_we     = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
        a_addr   = 32'($urandom_range(0, 15));
        a_wd     = $urandom;
      end
      st = stall_bus_t'($urandom_range(0, 63));
      do_cycle(c_en, c_we, c_addr, c_wd, aux_pend, a_we, a_addr, a_wd, st);
      if (last_gnt) aux_pend = 1'b0;
      cpu_hold = last_stallreq;
    end

    drive_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("aux_queue_drained", 32'(aux_q.size()), 32'h0);
    chk("cpu_queue_drained", 32'(cpu_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
